mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_if.sv | 32 +++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if.sv
// Memory request/response bus between an initiator and a responder.
// Req/MemWrite/DataAdr/WriteData/ByteEn flow out; ReadData/Ready(/Err) back.
interface mem_if;
  logic        Req;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [3:0]  ByteEn;
  logic [31:0] ReadData;
  logic        Ready;
`ifdef MEM_ERR_EN
  logic        Err;

  modport master (
    output Req, MemWrite, DataAdr, WriteData, ByteEn,
    input  ReadData, Ready, Err
  );
  modport slave (
    input  Req, MemWrite, DataAdr, WriteData, ByteEn,
    output ReadData, Ready, Err
  );
`else
  modport master (
    output Req, MemWrite, DataAdr, WriteData, ByteEn,
    input  ReadData, Ready
  );
  modport slave (
    input  Req, MemWrite, DataAdr, WriteData, ByteEn,
    output ReadData, Ready
  );
`endif
endinterface

// File: rtl/mem_responder.sv
// Word memory responder with WAIT_CYCLES wait states and a one-cycle Ready.
// Ports: clk, reset (sync, active-high), bus (mem_if.slave). MEM_ERR_EN adds Err.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic  clk,
  input  logic  reset,
  mem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wd_q, wd_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          acc;
  logic          acc_we;
  logic [31:0]   acc_adr;
  logic [31:0]   acc_wd;
  logic [3:0]    acc_be;
  logic [AW-1:0] acc_idx;
  logic          acc_ok;
  logic          wr_en;
  logic          unused_bits;

  // With zero wait states the access happens on the accept edge,
  // so the live bus is used; otherwise the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we  = bus.MemWrite;
      acc_adr = bus.DataAdr;
      acc_wd  = bus.WriteData;
      acc_be  = bus.ByteEn;
    end else begin
      acc_we  = we_q;
      acc_adr = adr_q;
      acc_wd  = wd_q;
      acc_be  = be_q;
    end
    acc_idx = acc_adr[AW+1:2];
`ifdef MEM_ERR_EN
    acc_ok  = (acc_adr[31:AW+2] == '0) && (acc_adr[1:0] == 2'b00);
`else
    acc_ok  = (acc_adr[31:AW+2] == '0);
`endif
  end

  assign unused_bits = ^acc_adr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    acc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Req) begin
          we_d  = bus.MemWrite;
          adr_d = bus.DataAdr;
          wd_d  = bus.WriteData;
          be_d  = bus.ByteEn;
          cnt_d = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            acc     = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          acc     = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (acc && !acc_we) begin
      rdata_d = acc_ok ? mem_q[acc_idx] : 32'h0;
    end
    err_d = acc && !acc_ok;
  end

  // Reset on the commit edge wins, so no write lands.
  assign wr_en = acc && acc_we && acc_ok && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      adr_q   <= 32'h0;
      wd_q    <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wd[8*i +: 8];
        end
      end
    end
  end

  assign bus.Ready    = (state_q == RESP);
  assign bus.ReadData = rdata_q;
`ifdef MEM_ERR_EN
  assign bus.Err      = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a
// transaction-level model (edge numbers, byte-masked word array).
module tb_mem_responder;
  localparam int DEPTH = 64;
  localparam int W     = 2;
`ifdef MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mem_if bif();

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif)
  );

  always #5 clk = ~clk;

  // model state
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_rdata = 32'h0;
  bit          rd_known = 1'b0;
  bit          m_err = 1'b0;
  bit          started = 1'b0;
  bit          busy = 1'b0;
  int          edge_n = 0;
  int          done_edge = 0;
  int          free_edge = 0;
  int          resp_edge = -10;
  bit          c_we;
  logic [31:0] c_adr, c_wd;
  logic [3:0]  c_be;

  function automatic void commit();
    bit ok;
    int idx;
    ok  = (c_adr < 32'(DEPTH * 4));
    if (ERR_EN && c_adr[1:0] != 2'b00) ok = 1'b0;
    idx = int'(c_adr >> 2) % DEPTH;
    m_err = ERR_EN && !ok;
    if (c_we) begin
      if (ok) begin
        for (int b = 0; b < 4; b++)
          if (c_be[b]) m_mem[idx][8*b +: 8] = c_wd[8*b +: 8];
        if (c_be == 4'hF) m_known[idx] = 1'b1;
      end
    end else begin
      m_rdata  = ok ? m_mem[idx] : 32'h0;
      rd_known = ok ? m_known[idx] : 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      busy = 1'b0;
      free_edge = edge_n + 1;
      resp_edge = -10;
      m_rdata = 32'h0;
      rd_known = 1'b1;
      m_err = 1'b0;
      started = 1'b1;
    end else if (busy) begin
      if (edge_n == done_edge) begin
        commit();
        busy = 1'b0;
        resp_edge = edge_n;
      end
    end else if (bif.Req && edge_n >= free_edge) begin
      c_we  = bif.MemWrite;
      c_adr = bif.DataAdr;
      c_wd  = bif.WriteData;
      c_be  = bif.ByteEn;
      done_edge = edge_n + W;
      free_edge = edge_n + W + 2;
      if (W == 0) begin
        commit();
        resp_edge = edge_n;
      end else begin
        busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (bif.Ready !== (resp_edge == edge_n)) begin
        failures++;
        $display("FAIL cmp_ready t=%0t act=%b exp=%b",
                 $time, bif.Ready, (resp_edge == edge_n));
      end
      if (rd_known) begin
        checks++;
        if (bif.ReadData !== m_rdata) begin
          failures++;
          $display("FAIL cmp_rdata t=%0t act=%h exp=%h",
                   $time, bif.ReadData, m_rdata);
        end
      end
`ifdef MEM_ERR_EN
      checks++;
      if (bif.Err !== (resp_edge == edge_n && m_err)) begin
        failures++;
        $display("FAIL cmp_err t=%0t act=%b exp=%b",
                 $time, bif.Err, (resp_edge == edge_n && m_err));
      end
`endif
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input bit we, input logic [31:0] adr,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] rd, output bit er,
                     output int lat);
    step();
    bif.Req = 1'b1;
    bif.MemWrite = we;
    bif.DataAdr = adr;
    bif.WriteData = wd;
    bif.ByteEn = be;
    lat = 0;
    rd = 32'h0;
    er = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bif.Ready) begin
        lat = k;
        rd = bif.ReadData;
`ifdef MEM_ERR_EN
        er = bif.Err;
`endif
        break;
      end
      bif.MemWrite = 1'($urandom);
      bif.DataAdr = $urandom;
      bif.WriteData = $urandom;
      bif.ByteEn = 4'($urandom);
    end
    bif.Req = 1'b0;
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout act=none exp=Ready");
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] v;
    bit er;
    int lat;
    int k;
    bif.Req = 1'b0;
    bif.MemWrite = 1'b0;
    bif.DataAdr = 32'h0;
    bif.WriteData = 32'h0;
    bif.ByteEn = 4'h0;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    chk("rst_ready", 32'(bif.Ready), 32'h0);
    chk("rst_rdata", bif.ReadData, 32'h0);

    for (int w = 0; w < DEPTH; w++) begin
      v = $urandom;
      if (w == 0) v = 32'hC0DE0000;
      if (w == 2) v = 32'h0BAD0002;
      if (w == 5) v = 32'hAABBCCDD;
      txn(1'b1, 32'(w * 4), v, 4'hF, rd, er, lat);
    end

    txn(1'b1, 32'd252, 32'h00001000, 4'hF, rd, er, lat);
    chk("wr252_lat", 32'(lat), 32'(W + 1));
    txn(1'b0, 32'd252, 32'h0, 4'h0, rd, er, lat);
    chk("rd252_data", rd, 32'h00001000);
    chk("rd252_lat", 32'(lat), 32'(W + 1));
    repeat (5) step();
    chk("rd252_hold", bif.ReadData, 32'h00001000);

    txn(1'b1, 32'd20, 32'h11223344, 4'b0101, rd, er, lat);
    txn(1'b0, 32'd20, 32'h0, 4'hF, rd, er, lat);
    chk("byteen_w5", rd, 32'hAA22CC44);

    txn(1'b1, 32'd256, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    chk("oor_wr_lat", 32'(lat), 32'(W + 1));
    chk("oor_wr_err", 32'(er), 32'(ERR_EN));
    txn(1'b0, 32'd256, 32'h0, 4'h0, rd, er, lat);
    chk("oor_rd_data", rd, 32'h0);
    txn(1'b0, 32'd0, 32'h0, 4'h0, rd, er, lat);
    chk("oor_no_alias", rd, 32'hC0DE0000);

    step();
    bif.Req = 1'b1;
    bif.MemWrite = 1'b1;
    bif.DataAdr = 32'd8;
    bif.WriteData = 32'hDEADBEEF;
    bif.ByteEn = 4'hF;
    step();
    reset = 1'b1;
    bif.Req = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_no_ready", 32'(bif.Ready), 32'h0);
    end
    txn(1'b0, 32'd8, 32'h0, 4'h0, rd, er, lat);
    chk("abort_w2", rd, 32'h0BAD0002);
    chk("abort_next_lat", 32'(lat), 32'(W + 1));

    reset = 1'b1;
    bif.Req = 1'b1;
    bif.MemWrite = 1'b1;
    bif.DataAdr = 32'd12;
    bif.WriteData = 32'h12345678;
    bif.ByteEn = 4'hF;
    repeat (2) step();
    reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bif.Ready) begin
        k = i;
        break;
      end
    end
    bif.Req = 1'b0;
    chk("req_in_reset_lat", 32'(k), 32'(W + 1));

`ifdef MEM_ERR_EN
    txn(1'b0, 32'd6, 32'h0, 4'h0, rd, er, lat);
    chk("mis_rd_data", rd, 32'h0);
    chk("mis_rd_err", 32'(er), 32'h1);
    txn(1'b1, 32'd9, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    chk("mis_wr_err", 32'(er), 32'h1);
    txn(1'b0, 32'd8, 32'h0, 4'h0, rd, er, lat);
    chk("al_rd_err", 32'(er), 32'h0);
    chk("mis_wr_drop", rd, 32'h0BAD0002);
`endif

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if ($urandom_range(0, 9) < 7) begin
        a = 32'($urandom_range(0, DEPTH - 1) * 4);
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
      end else if ($urandom_range(0, 1) == 0) begin
        a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000));
      end else begin
        a = $urandom | 32'h8000_0000;
      end
      if (sel == 0) begin
        step();
        bif.Req = 1'b1;
        bif.MemWrite = 1'b1;
        bif.DataAdr = a;
        bif.WriteData = $urandom;
        bif.ByteEn = 4'($urandom);
        repeat ($urandom_range(1, W + 2)) step();
        bif.Req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        txn(1'($urandom), a, $urandom, 4'($urandom), rd, er, lat);
      end
    end

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
